// File: rtl/memory_write_ctrl_if.sv
// Ingress byte, free-list, memory-write and frame-report signals of one
// memory_write_ctrl instance; master is the controller side.
interface memory_write_ctrl_if #(
    parameter int ADDR_W      = 10,
    parameter int BLOCK_BYTES = 64,
    parameter int DATA_WIDTH  = 8,
    parameter int LEN_W       = 16,
    parameter int CNT_W       = $clog2(BLOCK_BYTES + 1)
);
    logic                                    data_valid_i;
    logic [DATA_WIDTH-1:0]                   data_i;
    logic                                    data_end_i;
    logic                                    data_err_i;
    logic                                    ready_o;
    logic                                    alloc_req_o;
    logic                                    alloc_gnt_i;
    logic [ADDR_W-1:0]                       alloc_block_idx_i;
    logic                                    mem_we_o;
    logic                                    mem_gnt_i;
    logic [ADDR_W-1:0]                       mem_waddr_o;
    logic [BLOCK_BYTES-1:0][DATA_WIDTH-1:0]  mem_wdata_o;
    logic [ADDR_W-1:0]                       mem_next_o;
    logic                                    mem_last_o;
    logic [CNT_W-1:0]                        mem_count_o;
    logic                                    frame_done_o;
    logic [ADDR_W-1:0]                       frame_start_ptr_o;
    logic [LEN_W-1:0]                        frame_len_o;
    logic                                    frame_err_o;

    modport master (
        input  data_valid_i, data_i, data_end_i, data_err_i,
        input  alloc_gnt_i, alloc_block_idx_i, mem_gnt_i,
        output ready_o, alloc_req_o, mem_we_o, mem_waddr_o,
        output mem_wdata_o, mem_next_o, mem_last_o, mem_count_o,
        output frame_done_o, frame_start_ptr_o, frame_len_o,
        output frame_err_o
    );

    modport slave (
        output data_valid_i, data_i, data_end_i, data_err_i,
        output alloc_gnt_i, alloc_block_idx_i, mem_gnt_i,
        input  ready_o, alloc_req_o, mem_we_o, mem_waddr_o,
        input  mem_wdata_o, mem_next_o, mem_last_o, mem_count_o,
        input  frame_done_o, frame_start_ptr_o, frame_len_o,
        input  frame_err_o
    );
endinterface

// File: rtl/memory_write_ctrl.sv
// Packs one port's ingress bytes into linked memory blocks and reports
// each stored frame's head pointer, length and error flag.
module memory_write_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int BLOCK_BYTES = 64,
    parameter int DATA_WIDTH  = 8,
    parameter int LEN_W       = 16,
    parameter int CNT_W       = $clog2(BLOCK_BYTES + 1)
) (
    input logic                 clk,
    input logic                 rst,
    memory_write_ctrl_if.master bus
);
    localparam int IDX_W = $clog2(BLOCK_BYTES);

    typedef enum logic [1:0] {ALLOC, FILL, WRITE} state_t;

    state_t                                 state;
    logic [ADDR_W-1:0]                      spare;
    logic                                   spare_valid;
    logic [ADDR_W-1:0]                      cur_addr;
    logic [ADDR_W-1:0]                      head;
    logic [CNT_W-1:0]                       cnt;
    logic [LEN_W-1:0]                       len;
    logic                                   err;
    logic                                   last;
    logic [BLOCK_BYTES-1:0][DATA_WIDTH-1:0] blk;
    logic                                   done_q;
    logic [ADDR_W-1:0]                      done_ptr;
    logic [LEN_W-1:0]                       done_len;
    logic                                   done_err;

    logic xfer;
    logic in_wr;
    logic wr_go;

    assign xfer  = bus.data_valid_i && (state == FILL);
    assign in_wr = (state == WRITE);
    assign wr_go = bus.mem_we_o && bus.mem_gnt_i;

    // A non-final block may only go out once its successor is known.
    assign bus.ready_o     = (state == FILL);
    assign bus.alloc_req_o = !spare_valid;
    assign bus.mem_we_o    = in_wr && (last || spare_valid);
    assign bus.mem_waddr_o = cur_addr;
    assign bus.mem_wdata_o = blk;
    assign bus.mem_count_o = cnt;
    assign bus.mem_last_o  = in_wr && last;
    assign bus.mem_next_o  = (in_wr && !last) ? spare : '0;

    assign bus.frame_done_o      = done_q;
    assign bus.frame_start_ptr_o = done_ptr;
    assign bus.frame_len_o       = done_len;
    assign bus.frame_err_o       = done_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ALLOC;
            spare       <= '0;
            spare_valid <= 1'b0;
            cur_addr    <= '0;
            head        <= '0;
            cnt         <= '0;
            len         <= '0;
            err         <= 1'b0;
            last        <= 1'b0;
            blk         <= '0;
            done_q      <= 1'b0;
            done_ptr    <= '0;
            done_len    <= '0;
            done_err    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.alloc_gnt_i) begin
                spare       <= bus.alloc_block_idx_i;
                spare_valid <= 1'b1;
            end
            unique case (state)
                ALLOC: begin
                    if (spare_valid) begin
                        cur_addr    <= spare;
                        head        <= spare;
                        spare_valid <= 1'b0;
                        cnt         <= '0;
                        len         <= '0;
                        err         <= 1'b0;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (xfer) begin
                        blk[cnt[IDX_W-1:0]] <= bus.data_i;
                        cnt <= cnt + 1'b1;
                        if (len != '1) len <= len + 1'b1;
                        if (bus.data_end_i) err <= err | bus.data_err_i;
                        if (bus.data_end_i ||
                            cnt == CNT_W'(BLOCK_BYTES - 1)) begin
                            last  <= bus.data_end_i;
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (wr_go) begin
                        blk <= '0;
                        if (last) begin
                            done_q   <= 1'b1;
                            done_ptr <= head;
                            done_len <= len;
                            done_err <= err;
                            state    <= ALLOC;
                        end else begin
                            cur_addr    <= spare;
                            spare_valid <= 1'b0;
                            cnt         <= '0;
                            state       <= FILL;
                        end
                    end
                end
                default: state <= ALLOC;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_write_ctrl.sv
// Scoreboard bench for memory_write_ctrl: free-list and arbiter models,
// expected blocks and frame reports queued as frames are driven.
module tb_memory_write_ctrl;
    localparam int AW = 10;
    localparam int BB = 64;
    localparam int DW = 8;
    localparam int LW = 16;
    localparam int CW = $clog2(BB + 1);
    localparam int WW = BB * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_write_ctrl_if #(
        .ADDR_W(AW), .BLOCK_BYTES(BB), .DATA_WIDTH(DW),
        .LEN_W(LW), .CNT_W(CW)
    ) bus ();

    memory_write_ctrl #(
        .ADDR_W(AW), .BLOCK_BYTES(BB), .DATA_WIDTH(DW),
        .LEN_W(LW), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] next;
        logic          last;
        logic [CW-1:0] count;
        logic [WW-1:0] data;
    } blk_t;

    typedef struct {
        logic [AW-1:0] head;
        logic [LW-1:0] len;
        logic          err;
    } frm_t;

    blk_t blk_q[$];
    frm_t frm_q[$];
    int   seq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   alloc_limit = 0;
    int   stall_cfg = 0;
    int   gi = 0;
    int   stalled = 0;
    int   mp = 0;

    task automatic check(input string tag, input logic [WW-1:0] got,
                         input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Free-list model: grants the next planned index while requested.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            gi = 0;
            bus.alloc_gnt_i = 1'b0;
            bus.alloc_block_idx_i = '0;
        end else if (bus.alloc_req_o && gi < alloc_limit &&
                     gi < seq.size()) begin
            bus.alloc_gnt_i = 1'b1;
            bus.alloc_block_idx_i = AW'(seq[gi]);
            gi++;
        end else begin
            bus.alloc_gnt_i = 1'b0;
        end
    end

    // Arbiter model: grants after stall_cfg waiting cycles.
    always @(posedge clk) begin
        #1;
        if (rst || !bus.mem_we_o) begin
            stalled = 0;
            bus.mem_gnt_i = 1'b0;
        end else if (stalled < stall_cfg) begin
            stalled++;
            bus.mem_gnt_i = 1'b0;
        end else begin
            stalled = 0;
            bus.mem_gnt_i = 1'b1;
        end
    end

    logic prev_stall = 1'b0;
    blk_t snap;
    blk_t mb;
    frm_t mf;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.mem_we_o) check("ready_in_write", bus.ready_o, 0);
            if (bus.mem_we_o && prev_stall) begin
                check("stall_addr", bus.mem_waddr_o, snap.addr);
                check("stall_next", bus.mem_next_o, snap.next);
                check("stall_last", bus.mem_last_o, snap.last);
                check("stall_count", bus.mem_count_o, snap.count);
                check("stall_data", bus.mem_wdata_o, snap.data);
            end
            if (bus.mem_we_o && bus.mem_gnt_i) begin
                check("write_expected", blk_q.size() != 0, 1);
                if (blk_q.size() != 0) begin
                    mb = blk_q.pop_front();
                    check("waddr", bus.mem_waddr_o, mb.addr);
                    check("wnext", bus.mem_next_o, mb.next);
                    check("wlast", bus.mem_last_o, mb.last);
                    check("wcount", bus.mem_count_o, mb.count);
                    check("wdata", bus.mem_wdata_o, mb.data);
                end
                prev_stall = 1'b0;
            end else if (bus.mem_we_o) begin
                prev_stall = 1'b1;
                snap.addr  = bus.mem_waddr_o;
                snap.next  = bus.mem_next_o;
                snap.last  = bus.mem_last_o;
                snap.count = bus.mem_count_o;
                snap.data  = bus.mem_wdata_o;
            end else begin
                prev_stall = 1'b0;
            end
            if (bus.frame_done_o) begin
                check("frame_expected", frm_q.size() != 0, 1);
                if (frm_q.size() != 0) begin
                    mf = frm_q.pop_front();
                    check("frame_head", bus.frame_start_ptr_o, mf.head);
                    check("frame_len", bus.frame_len_o, mf.len);
                    check("frame_err", bus.frame_err_o, mf.err);
                end
            end
        end
    end

    function automatic logic [AW-1:0] seq_at(input int i);
        return (i < seq.size()) ? AW'(seq[i]) : '0;
    endfunction

    task automatic push_frame(input int n, input logic [7:0] base,
                              input logic errend);
        int nb;
        blk_t e;
        frm_t f;
        nb = (n + BB - 1) / BB;
        for (int b = 0; b < nb; b++) begin
            e.addr  = seq_at(mp + b);
            e.last  = (b == nb - 1);
            e.next  = e.last ? '0 : seq_at(mp + b + 1);
            e.count = CW'(e.last ? n - BB * b : BB);
            e.data  = '0;
            for (int i = 0; i < int'(e.count); i++)
                e.data[8*i +: 8] = base + 8'(BB * b + i);
            blk_q.push_back(e);
        end
        f.head = seq_at(mp);
        f.len  = LW'(n);
        f.err  = errend;
        frm_q.push_back(f);
        mp += nb;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic e,
                             input logic er);
        int t;
        t = 0;
        bus.data_i = d;
        bus.data_end_i = e;
        bus.data_err_i = er;
        bus.data_valid_i = 1'b1;
        while (!bus.ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("accept", bus.ready_o, 1);
        @(negedge clk);
        bus.data_valid_i = 1'b0;
        bus.data_end_i = 1'b0;
        bus.data_err_i = 1'b0;
    endtask

    task automatic send_part(input int n, input logic [7:0] base,
                             input logic errend, input int errmid,
                             input int lo, input int hi);
        for (int k = lo; k < hi; k++)
            send_byte(base + 8'(k), k == n - 1,
                      (k == n - 1) ? errend : (k == errmid));
    endtask

    task automatic send_frame(input int n, input logic [7:0] base,
                              input logic errend, input int errmid);
        push_frame(n, base, errend);
        send_part(n, base, errend, errmid, 0, n);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((blk_q.size() != 0 || frm_q.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain", blk_q.size() + frm_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.data_valid_i = 1'b0;
        bus.data_end_i = 1'b0;
        bus.data_err_i = 1'b0;
        blk_q.delete();
        frm_q.delete();
        mp = 0;
        stall_cfg = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_rst_vals();
        check("rst_ready", bus.ready_o, 0);
        check("rst_alloc_req", bus.alloc_req_o, 1);
        check("rst_we", bus.mem_we_o, 0);
        check("rst_last", bus.mem_last_o, 0);
        check("rst_waddr", bus.mem_waddr_o, 0);
        check("rst_next", bus.mem_next_o, 0);
        check("rst_count", bus.mem_count_o, 0);
        check("rst_wdata", bus.mem_wdata_o, 0);
        check("rst_done", bus.frame_done_o, 0);
        check("rst_ptr", bus.frame_start_ptr_o, 0);
        check("rst_len", bus.frame_len_o, 0);
        check("rst_ferr", bus.frame_err_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_i = '0;
        bus.data_valid_i = 1'b0;
        bus.data_end_i = 1'b0;
        bus.data_err_i = 1'b0;
        repeat (2) @(negedge clk);
        check_rst_vals();

        // 1-byte frame, preceded by an end flag with no transfer
        seq = '{5, 6};
        alloc_limit = 8;
        do_reset();
        bus.data_end_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.data_end_i = 1'b0;
        push_frame(1, 8'hA5, 1'b0);
        send_byte(8'hA5, 1'b1, 1'b0);
        check("we_latency", bus.mem_we_o, 1);
        @(negedge clk);
        check("done_latency", bus.frame_done_o, 1);
        wait_idle();

        // exact fit, then spare 7 heads the next frame
        seq = '{3, 7};
        do_reset();
        send_frame(64, 8'h10, 1'b0, -1);
        wait_idle();
        send_frame(3, 8'h40, 1'b0, -1);
        wait_idle();

        // two-block frame, spare 9 heads the next frame
        seq = '{3, 7, 9};
        do_reset();
        send_frame(65, 8'h80, 1'b0, -1);
        wait_idle();
        send_frame(2, 8'hC0, 1'b0, -1);
        wait_idle();

        // backpressure: no spare at the boundary, then 5 stall cycles
        seq = '{3, 7, 9};
        alloc_limit = 1;
        do_reset();
        push_frame(65, 8'h20, 1'b0);
        send_part(65, 8'h20, 1'b0, -1, 0, 64);
        repeat (4) begin
            check("bp_we_low", bus.mem_we_o, 0);
            check("bp_ready_low", bus.ready_o, 0);
            check("bp_alloc_req", bus.alloc_req_o, 1);
            @(negedge clk);
        end
        stall_cfg = 5;
        alloc_limit = 8;
        send_part(65, 8'h20, 1'b0, -1, 64, 65);
        wait_idle();
        stall_cfg = 0;

        // back-to-back frames; mid-frame error flag must be ignored
        seq = '{1, 2, 4};
        do_reset();
        send_frame(10, 8'h01, 1'b0, 4);
        send_frame(10, 8'h61, 1'b1, -1);
        wait_idle();

        // reset after 30 bytes, then a clean 5-byte frame
        seq = '{3, 5};
        do_reset();
        send_part(40, 8'h00, 1'b0, -1, 0, 30);
        rst = 1'b1;
        #1;
        check_rst_vals();
        seq = '{6};
        do_reset();
        send_frame(5, 8'h55, 1'b1, -1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/memory_write_ctrl.md
# memory_write_ctrl

Packs the received byte stream of one ingress port into fixed-size memory blocks, links them into a per-frame chain, and writes each block to shared frame memory through the write arbiter. Block addresses come from the free list; one spare block index is always prefetched, so the next-block link is known when each block is written. On frame completion it reports the head block pointer and byte length to the forwarding/crossbar path. It is the write-side counterpart of `memory_read_ctrl`, and one instance sits per port in the input path.

## Interface
- `ADDR_W`, `mem_pkg::ADDR_W`: block index width.
- `BLOCK_BYTES`, `mem_pkg::BLOCK_BYTES` (64): data bytes per block.
- `DATA_WIDTH`, `rx_tx_pkg::DATA_WIDTH` (8): byte width.
- `LEN_W`, 16: frame length width.
- `CNT_W`, `$clog2(BLOCK_BYTES+1)`: per-block byte count width.

Ports:
- `clk`  in  1  switch clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_i`  in  DATA_WIDTH  ingress byte.
- `data_valid_i`  in  1  byte valid; a byte transfers when `data_valid_i && ready_o`.
- `data_end_i`  in  1  last byte of the frame; qualified by the transfer.
- `data_err_i`  in  1  frame error; sampled on the end transfer.
- `ready_o`  out  1  byte accept.
- `alloc_req_o`  out  1  free-list allocation request (level).
- `alloc_gnt_i`  in  1  allocation grant.
- `alloc_block_idx_i`  in  ADDR_W  granted block index.
- `mem_we_o`  out  1  block write request; held until granted.
- `mem_gnt_i`  in  1  arbiter grant; the write completes in this cycle.
- `mem_waddr_o`  out  ADDR_W  block index.
- `mem_wdata_o`  out  [BLOCK_BYTES-1:0][DATA_WIDTH-1:0]  data; byte i of the block is in element i.
- `mem_next_o`  out  ADDR_W  link to the next block; 0 when `mem_last_o`=1.
- `mem_last_o`  out  1  final block of the frame.
- `mem_count_o`  out  CNT_W  valid bytes in the block (1..BLOCK_BYTES).
- `frame_done_o`  out  1  one-cycle pulse when the frame is stored.
- `frame_start_ptr_o`  out  ADDR_W  head block; valid with `frame_done_o`.
- `frame_len_o`  out  LEN_W  frame bytes; valid with `frame_done_o`.
- `frame_err_o`  out  1  latched `data_err_i`; valid with `frame_done_o`.

## Operation
- **Spare register:** `spare`/`spare_valid`. `alloc_req_o = !spare_valid`. When `alloc_gnt_i` is high, capture `alloc_block_idx_i` and set `spare_valid`. A grant can only arrive while the spare is empty, so a grant and a consume never collide.
- **Assembly buffer:** BLOCK_BYTES bytes, a byte counter `cnt`, and `cur_addr`. Unwritten bytes read as 0.
- **FSM states:** ALLOC, FILL, WRITE.
- **ALLOC** (state after reset):
  - `ready_o=0`.
  - When `spare_valid`: `cur_addr<=spare`, `head<=spare`, clear `spare_valid`, `cnt<=0`, `len<=0`, `err<=0`, then go to FILL.
- **FILL:**
  - `ready_o=1`.
  - Each transfer stores `data_i` at index `cnt`, then `cnt++` and `len++`. `len` saturates at all-ones.
  - `err` ORs in `data_err_i` on the end transfer.
  - Go to WRITE when the transfer fills the block (`cnt==BLOCK_BYTES-1`) or carries `data_end_i`. Record `last=data_end_i`.
  - `data_end_i` without a transfer is ignored.
- **WRITE:**
  - `ready_o=0`.
  - `mem_we_o = last || spare_valid`.
  - `mem_waddr_o=cur_addr`, `mem_count_o=cnt`, `mem_last_o=last`, `mem_next_o = last ? 0 : spare`.
  - On `mem_we_o && mem_gnt_i`:
    - last=1: pulse `frame_done_o` next cycle with `head`, `len`, `err`; go to ALLOC.
    - last=0: `cur_addr<=spare`, clear `spare_valid`, `cnt<=0`, clear the buffer; go to FILL.
- A block that fills on exactly the end byte is written with last=1, so no empty trailing block is ever produced.
- **Reset mid-operation:** all state clears. Prefetched or partially written blocks are not returned, because the free list shares the same reset.

## Timing
- **Reset values:** `ready_o=0`, `alloc_req_o=1` (spare empty), `mem_we_o=0`, `mem_last_o=0`, `mem_waddr_o/mem_next_o/mem_count_o/mem_wdata_o=0`, `frame_done_o=0`, `frame_start_ptr_o=0`, `frame_len_o=0`, `frame_err_o=0`.
- State and buffer are registered. `ready_o`, `mem_we_o`, `alloc_req_o` and the `mem_*` fields decode from registered state only; none depends combinationally on `*_gnt_i`.
- **Block write latency:** the last byte of a block transfers in cycle t; `mem_we_o` is high in t+1.
  - With grant in t+1: FILL resumes in t+2 (`ready_o=1`); `frame_done_o` is high in t+2 for a last block.
  - Each grant-stall cycle adds one cycle.
- **Minimum dead time per block:** 1 cycle (WRITE). Between frames it is 2 cycles (WRITE and ALLOC), provided the spare is already valid.
- **Free-list turnaround:** an allocation grant in cycle t makes the spare usable in t+1.

## Test plan
- **1-byte frame:** byte 0xA5 with `data_end_i`. Expect one write with `mem_count_o=1`, `mem_last_o=1`, `mem_next_o=0`, `mem_wdata_o` element 0 = 0xA5 and the rest 0. Then `frame_len_o=1`, `frame_start_ptr_o` = first allocated index.
- **Exact fit:** 64-byte frame with allocs 3,7. Expect a single write to 3, count 64, last=1. Block 7 remains the spare; `frame_len_o=64`.
- **Two-block frame:** 65 bytes with allocs 3,7,9. Expect write(3, next=7, count 64, last=0), then write(7, count 1, last=1). `frame_start_ptr_o=3`, `frame_len_o=65`. The spare becomes 9.
- **Backpressure:** hold `mem_gnt_i` low 5 cycles and withhold `alloc_gnt_i` at the block boundary. Expect `mem_we_o` and all fields stable throughout, `ready_o=0`, no byte lost, and `mem_we_o` low until the spare arrives.
- **Back-to-back frames:** two 10-byte frames with the second presented immediately. Expect two `frame_done_o` pulses, distinct head pointers, and `frame_err_o` set only on the frame whose end byte carried `data_err_i`.
- **Reset mid-frame:** assert `rst` after 30 bytes. Expect all outputs at their reset values the same cycle. A following 5-byte frame stores correctly with `frame_len_o=5`.
